// File: rtl/audio_eq_pkg.sv
// Shared types for the audio equalizer sample path.
//   SMPL_W        : width of one signed Q1.15 audio sample
//   q_state_t     : sample-queue readout FSM states
//   stereo_smpl_t : one {left, right} stereo sample as stored in the queue RAM
package audio_eq_pkg;

    localparam int unsigned SMPL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } q_state_t;

    typedef struct packed {
        logic signed [SMPL_W-1:0] lft;
        logic signed [SMPL_W-1:0] rght;
    } stereo_smpl_t;

endpackage

// File: rtl/smpl_queue_if.sv
// Sample-queue bus: stereo samples in with a write strobe, a burst stream out to the FIR.
//   lft_smpl/rght_smpl/wrt_smpl : incoming sample and its 1-cycle valid strobe
//   lft_out/rght_out/sequencing : burst stream to the FIR, sequencing frames the burst
//   master : sample producer / FIR side
//   slave  : the queue itself
interface smpl_queue_if
    import audio_eq_pkg::*;
();
    logic signed [SMPL_W-1:0] lft_smpl;
    logic signed [SMPL_W-1:0] rght_smpl;
    logic                     wrt_smpl;
    logic signed [SMPL_W-1:0] lft_out;
    logic signed [SMPL_W-1:0] rght_out;
    logic                     sequencing;

    modport master (
        output lft_smpl, rght_smpl, wrt_smpl,
        input  lft_out, rght_out, sequencing
    );

    modport slave (
        input  lft_smpl, rght_smpl, wrt_smpl,
        output lft_out, rght_out, sequencing
    );
endinterface

// File: rtl/dpram_smpl.sv
// Simple dual-port stereo sample RAM, DEPTH x 32, block-RAM style.
//   clk   : clock
//   we    : write enable, wdata stored at waddr
//   re    : read enable, mem[raddr] appears on rdata the next cycle
//   rdata : holds its value when re is low; read-first on address collision
module dpram_smpl
    import audio_eq_pkg::*;
#(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  stereo_smpl_t  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output stereo_smpl_t  rdata
);

    stereo_smpl_t mem [DEPTH];

    // No reset so the array maps onto block RAM; NBAs make a same-address read return old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/smpl_queue.sv
// Circular stereo sample buffer feeding one FIR band filter.
// Every written sample is stored; once TAPS samples are held, each write triggers a
// burst that streams the newest TAPS samples oldest-first with sequencing high.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : smpl_queue_if.slave (sample in + strobe, burst stream out)
// Burst timing relative to the triggering write in cycle 0: first read in cycle 1,
// sequencing high in cycles 2..TAPS+2, samples on the outputs in cycles 3..TAPS+2.
module smpl_queue
    import audio_eq_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned TAPS  = 1021
) (
    input  logic         clk,
    input  logic         rst_n,
    smpl_queue_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(TAPS + 1);

    q_state_t                 state;
    q_state_t                 state_nxt;
    logic [AW-1:0]            new_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            rd_ptr_nxt;
    logic [AW-1:0]            cnt;
    logic [AW-1:0]            cnt_nxt;
    logic [AW-1:0]            rd_addr_c;
    logic                     rd_en_c;
    logic                     start_c;
    logic [FW-1:0]            fill;
    logic [FW-1:0]            fill_nxt;
    logic                     trig_c;
    logic                     pending;
    logic                     pending_nxt;
    logic                     seq_r;
    logic signed [SMPL_W-1:0] lft_r;
    logic signed [SMPL_W-1:0] rght_r;
    stereo_smpl_t             wr_data_c;
    stereo_smpl_t             rd_data;

    assign wr_data_c = '{lft: bus.lft_smpl, rght: bus.rght_smpl};

    // Fill count saturates at TAPS; any write that leaves it full requests a burst.
    always_comb begin
        fill_nxt = fill;
        if (bus.wrt_smpl && (fill != FW'(TAPS))) begin
            fill_nxt = fill + FW'(1);
        end
        trig_c = bus.wrt_smpl && (fill_nxt == FW'(TAPS));
    end

    // A write in the burst-start cycle re-arms pending after the start consumed it.
    always_comb begin
        pending_nxt = pending;
        if (start_c) begin
            pending_nxt = 1'b0;
        end
        if (trig_c) begin
            pending_nxt = 1'b1;
        end
    end

    // Next-state logic. The start cycle itself issues the first read (oldest sample,
    // pre-write new_ptr), so READ issues the remaining TAPS-1; DRAIN covers the RAM
    // and output-register latency.
    always_comb begin
        state_nxt  = state;
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = cnt;
        rd_addr_c  = rd_ptr;
        rd_en_c    = 1'b0;
        start_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    start_c    = 1'b1;
                    rd_en_c    = 1'b1;
                    rd_addr_c  = new_ptr - AW'(TAPS);
                    rd_ptr_nxt = rd_addr_c + AW'(1);
                    cnt_nxt    = AW'(1);
                    state_nxt  = READ;
                end
            end
            READ: begin
                rd_en_c    = 1'b1;
                rd_ptr_nxt = rd_ptr + AW'(1);
                if (cnt == AW'(TAPS - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = DRAIN;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            DRAIN: begin
                if (cnt == AW'(1)) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointers, counters and the registered burst stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_ptr <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            fill    <= '0;
            pending <= 1'b0;
            seq_r   <= 1'b0;
            lft_r   <= '0;
            rght_r  <= '0;
        end else begin
            if (bus.wrt_smpl) begin
                new_ptr <= new_ptr + AW'(1);
            end
            rd_ptr  <= rd_ptr_nxt;
            cnt     <= cnt_nxt;
            fill    <= fill_nxt;
            pending <= pending_nxt;
            // Sequencing spans READ plus DRAIN, one cycle behind the start.
            seq_r   <= (state_nxt != IDLE);
            if (seq_r) begin
                lft_r  <= rd_data.lft;
                rght_r <= rd_data.rght;
            end
        end
    end

    assign bus.sequencing = seq_r;
    assign bus.lft_out    = lft_r;
    assign bus.rght_out   = rght_r;

    dpram_smpl #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (bus.wrt_smpl),
        .waddr (new_ptr),
        .wdata (wr_data_c),
        .re    (rd_en_c),
        .raddr (rd_addr_c),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_smpl_queue.sv
// Testbench for smpl_queue with DEPTH=8, TAPS=5.
module tb_smpl_queue;

    localparam int DEPTH = 8;
    localparam int TAPS  = 5;

    logic clk;
    logic rst_n;
    int   cyc = 0;

    smpl_queue_if qif ();

    smpl_queue #(
        .DEPTH (DEPTH),
        .TAPS  (TAPS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: sample history, fill level, pending flag and the active burst.
    logic [31:0] m_hist[$];
    logic [31:0] m_win[TAPS];
    int          m_fill    = 0;
    bit          m_pending = 0;
    bit          m_active  = 0;
    bit          m_loaded  = 0;
    int          m_s       = 0;

    // Capture of a 32-cycle window starting at an armed write.
    bit          cap_arm = 0;
    bit          cap_on  = 0;
    int          cap_c0  = 0;
    logic [31:0] cap_seq;
    logic [15:0] cap_l[32];
    logic [15:0] cap_r[32];

    typedef struct {
        int          k;
        int          gap;
        logic [31:0] exp_seq;
        int          exp_first;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_fill    = 0;
        m_pending = 0;
        m_active  = 0;
        m_loaded  = 0;
    endtask

    // One clock cycle: check outputs against the model, capture, drive inputs, advance the model.
    task automatic tick(input logic wr, input logic [15:0] l, input logic [15:0] r);
        int          c;
        int          rel;
        logic        exp_seq;
        logic        dv;
        logic [31:0] smp;
        @(negedge clk);
        c       = cyc;
        exp_seq = 1'b0;
        dv      = 1'b0;
        smp     = '0;
        if (m_active) begin
            rel = c - m_s;
            if (rel >= 1 && rel <= TAPS + 1) exp_seq = 1'b1;
            if (rel >= 2 && rel <= TAPS + 1) begin
                dv       = 1'b1;
                smp      = m_win[rel-2];
                m_loaded = 1;
            end
            if (rel >= TAPS + 2) m_active = 0;
        end
        chk($sformatf("seq@%0d", c), 32'(qif.sequencing), 32'(exp_seq));
        if (dv) begin
            chk($sformatf("lft@%0d", c), 32'($signed(qif.lft_out)), 32'($signed(smp[31:16])));
            chk($sformatf("rght@%0d", c), 32'($signed(qif.rght_out)), 32'($signed(smp[15:0])));
        end else if (!m_loaded) begin
            chk($sformatf("lft_zero@%0d", c), 32'($signed(qif.lft_out)), 32'd0);
            chk($sformatf("rght_zero@%0d", c), 32'($signed(qif.rght_out)), 32'd0);
        end
        if (cap_arm) begin
            cap_arm = 0;
            cap_on  = 1;
            cap_c0  = c;
            cap_seq = '0;
        end
        if (cap_on && (c - cap_c0) < 32) begin
            cap_seq[c-cap_c0] = qif.sequencing;
            cap_l[c-cap_c0]   = qif.lft_out;
            cap_r[c-cap_c0]   = qif.rght_out;
        end
        qif.wrt_smpl  = wr;
        qif.lft_smpl  = l;
        qif.rght_smpl = r;
        if (rst_n) begin
            if (!m_active && m_pending) begin
                m_active  = 1;
                m_s       = c;
                m_pending = 0;
                for (int i = 0; i < TAPS; i++) m_win[i] = m_hist[m_hist.size() - TAPS + i];
            end
            if (wr) begin
                m_hist.push_back({l, r});
                if (m_hist.size() > TAPS) void'(m_hist.pop_front());
                if (m_fill < TAPS) m_fill++;
                if (m_fill == TAPS) m_pending = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0, '0);
    endtask

    // Armed write of sample k (lft=k, rght=-k), padded to 'gap' cycles total.
    task automatic wr_k(input int k, input int gap);
        cap_arm = 1;
        tick(1'b1, 16'(k), 16'(-k));
        idle(gap - 1);
    endtask

    // Window of TAPS samples first..first+TAPS-1 at capture offsets off..off+TAPS-1.
    task automatic chk_win(input string tag, input int off, input int first);
        for (int j = 0; j < TAPS; j++) begin
            chk($sformatf("%s_lft%0d", tag, j), 32'($signed(cap_l[off+j])), 32'(first + j));
            chk($sformatf("%s_rght%0d", tag, j), 32'($signed(cap_r[off+j])), 32'(-(first + j)));
        end
    endtask

    initial begin
        vecs[0]  = '{k: 1,  gap: 20, exp_seq: 32'h0000_0000, exp_first: 0};
        vecs[1]  = '{k: 2,  gap: 20, exp_seq: 32'h0000_0000, exp_first: 0};
        vecs[2]  = '{k: 3,  gap: 20, exp_seq: 32'h0000_0000, exp_first: 0};
        vecs[3]  = '{k: 4,  gap: 20, exp_seq: 32'h0000_0000, exp_first: 0};
        vecs[4]  = '{k: 5,  gap: 20, exp_seq: 32'h0000_00FC, exp_first: 1};
        vecs[5]  = '{k: 6,  gap: 20, exp_seq: 32'h0000_00FC, exp_first: 2};
        vecs[6]  = '{k: 7,  gap: 20, exp_seq: 32'h0000_00FC, exp_first: 3};
        vecs[7]  = '{k: 8,  gap: 20, exp_seq: 32'h0000_00FC, exp_first: 4};
        vecs[8]  = '{k: 9,  gap: 20, exp_seq: 32'h0000_00FC, exp_first: 5};
        vecs[9]  = '{k: 10, gap: 20, exp_seq: 32'h0000_00FC, exp_first: 6};
        vecs[10] = '{k: 11, gap: 20, exp_seq: 32'h0000_00FC, exp_first: 7};

        rst_n         = 1'b0;
        qif.wrt_smpl  = 1'b0;
        qif.lft_smpl  = '0;
        qif.rght_smpl = '0;
        repeat (3) @(negedge clk);
        chk("reset_seq", 32'(qif.sequencing), 32'd0);
        chk("reset_lft", 32'($signed(qif.lft_out)), 32'd0);
        chk("reset_rght", 32'($signed(qif.rght_out)), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Fill phase and single bursts, including pointer wrap.
        foreach (vecs[i]) begin
            wr_k(vecs[i].k, vecs[i].gap);
            chk($sformatf("seq_pattern_k%0d", vecs[i].k), cap_seq, vecs[i].exp_seq);
            if (vecs[i].exp_first > 0) chk_win($sformatf("k%0d", vecs[i].k), 3, vecs[i].exp_first);
        end

        // Write 13 lands 3 cycles into the burst of write 12.
        cap_arm = 1;
        tick(1'b1, 16'(12), 16'(-12));
        idle(2);
        tick(1'b1, 16'(13), 16'(-13));
        idle(28);
        chk("mid_burst_seq", cap_seq, 32'h0000_7EFC);
        chk_win("b12", 3, 8);
        chk_win("b13", 10, 9);

        // Two writes inside one burst collapse into one follow-on burst.
        cap_arm = 1;
        tick(1'b1, 16'(14), 16'(-14));
        idle(1);
        tick(1'b1, 16'(15), 16'(-15));
        idle(1);
        tick(1'b1, 16'(16), 16'(-16));
        idle(27);
        chk("two_wr_seq", cap_seq, 32'h0000_7EFC);
        chk_win("b14", 3, 10);
        chk_win("b16", 10, 12);

        // Asynchronous reset in the middle of a burst.
        tick(1'b1, 16'(17), 16'(-17));
        idle(4);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_seq", 32'(qif.sequencing), 32'd0);
        chk("rst_mid_lft", 32'($signed(qif.lft_out)), 32'd0);
        chk("rst_mid_rght", 32'($signed(qif.rght_out)), 32'd0);
        model_reset();
        idle(2);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 18; k <= 21; k++) begin
            wr_k(k, 20);
            chk($sformatf("post_rst_seq_k%0d", k), cap_seq, 32'h0000_0000);
        end
        wr_k(22, 20);
        chk("post_rst_seq_k22", cap_seq, 32'h0000_00FC);
        chk_win("k22", 3, 18);

        // Randomized traffic against the model; gaps >= 2 keep the burst window intact.
        cap_on = 0;
        for (int n = 0; n < 80; n++) begin
            tick(1'b1, 16'($urandom), 16'($urandom));
            idle(int'($urandom_range(1, 11)));
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
